scp_signal_conditioner: RTL and testbench
=========================================

Name: scp_signal_conditioner

Overview:
- Upstream input stage for scp_079: turns three raw, asynchronous, bouncy lamp/button inputs into clean, mutually exclusive green/yellow/red levels.
- Stages: synchronise, debounce, priority-arbitrate, enforce a minimum hold time, then drive the controller's green/yellow/red inputs from registered outputs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed before a clean level changes (≥1).
- HOLD_CYCLES, 8: minimum cycles an output level stays active before it may drop to a lower priority (≥1).
- STUCK_CYCLES, 63: stable-high cycles after which a channel is declared stuck (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- raw_green  in  1  asynchronous green request.
- raw_yellow  in  1  asynchronous yellow request.
- raw_red  in  1  asynchronous red request.
- green  out  1  conditioned green; connects to scp_079.green.
- yellow  out  1  conditioned yellow; connects to scp_079.yellow.
- red  out  1  conditioned red; connects to scp_079.red.
- level  out  2  encoded active level: 0 none, 1 green, 2 yellow, 3 red.
- changed  out  1  one-cycle pulse in the cycle level takes a new value.
- stuck  out  3  per-channel stuck flags {red,yellow,green}; tied to 0 without the optional feature.

Behaviour:
- Reset (async, active-high):
  - All sync flops, clean levels, debounce counters and hold counter go to 0; FSM goes to NONE.
  - green, yellow, red, changed and stuck go to 0 and level goes to 0 immediately, without waiting for a clock edge.
  - Assertion mid-operation aborts any hold or debounce in progress.
  - After release, operation restarts from NONE.
- Synchronisation: two flops per raw input.
- Debounce, per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while the synchronised value differs from the clean value and clears on any agreeing sample.
  - When it reaches DEBOUNCE_CYCLES, the clean value toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches the clean value.
- Request: priority encode of the clean levels, red > yellow > green > none.
- FSM states: NONE, GREEN, YELLOW, RED, with a saturating hold counter that clears on every state entry.
  - Request of higher priority than the current state: transition at the next edge (preemption ignores hold).
  - Request of lower priority, including none: transition only when hold count ≥ HOLD_CYCLES-1, i.e. after the state has been active for HOLD_CYCLES cycles. Otherwise stay.
  - Request equal to the current state: stay.
  - From NONE: any request transitions at the next edge.
  - A request that changes during hold is re-evaluated every cycle; only the request present when hold expires is taken.
- Outputs:
  - Registered decode of the state; green/yellow/red are one-hot or all zero, never two high.
  - level matches the state.
  - changed is high for exactly one cycle per state change.
- Latency: a raw input rising while the block is in NONE shows up on the output exactly 3+DEBOUNCE_CYCLES rising edges after the first edge that samples it high (7 with defaults).
- Simultaneous raw assertions resolve to the highest priority.
- A raw input that is already high when reset releases is treated as a new assertion.

Optional Feature:
- Macro: SCP_SIGNAL_CONDITIONER_STUCK_DETECT_EN.
- Defined:
  - Each channel has a stuck counter (width clog2(STUCK_CYCLES+1)) that counts while its clean level is 1.
  - When the count reaches STUCK_CYCLES, the matching stuck bit sets and that channel is masked from the request encoder.
  - The stuck bit and mask clear when the clean level returns to 0, or on reset.
  - Masking a channel follows the normal hold and preemption rules.
- Not defined: no stuck counters; stuck is constant 0; no masking.

Test Plan:
- Reset check: reset held while raw_red=1 → all outputs 0, level=0; after release, red=1 and level=3 exactly 7 edges later, changed pulses once.
- Glitch rejection: raw_green pulses high for 3 cycles → green never asserts, changed stays 0.
- Preemption: raw_green=1 settles to green; then raw_red=1 → red=1 with green=0 in the same cycle, 7 edges after the red assertion, regardless of hold.
- Hold enforcement: red active; raw_red drops 1 cycle after red asserts while raw_yellow=1 → yellow asserts only after red has been active 8 cycles (or after debounce, whichever is later); red and yellow never high together.
- Mid-operation reset: reset asserted during a YELLOW hold → all outputs 0 combinationally; after release with raw_yellow=1, yellow reasserts after 7 edges.
- Stuck (macro defined): raw_green held high → stuck[0]=1 and green drops (after the hold rule) 63 cycles after green's clean level rises; dropping raw_green clears stuck[0] after debounce.

Source files
------------

// File: rtl/scp_signal_conditioner_if.sv
// Raw request inputs and conditioned level outputs of scp_signal_conditioner.
// The master side drives the raw requests; the slave side is the conditioner.
interface scp_signal_conditioner_if;
  logic       raw_green;
  logic       raw_yellow;
  logic       raw_red;
  logic       green;
  logic       yellow;
  logic       red;
  logic [1:0] level;
  logic       changed;
  logic [2:0] stuck;

  modport master (
    output raw_green, raw_yellow, raw_red,
    input  green, yellow, red, level, changed, stuck
  );

  modport slave (
    input  raw_green, raw_yellow, raw_red,
    output green, yellow, red, level, changed, stuck
  );
endinterface

// File: rtl/scp_signal_conditioner.sv
// Sync, debounce, priority-arbitrate and hold-time filter for three lamp inputs.
// Optional stuck-channel masking: define SCP_SIGNAL_CONDITIONER_STUCK_DETECT_EN.
module scp_signal_conditioner_chan #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 63
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic stuck
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      db_cnt <= '0;
      clean  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      // Any sample agreeing with the clean level restarts the stability window.
      if (sync_q[1] == clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        clean  <= ~clean;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef SCP_SIGNAL_CONDITIONER_STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STUCK_CYCLES);

  logic [SW-1:0] stuck_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   stuck_cnt <= '0;
    else if (!clean)             stuck_cnt <= '0;
    else if (stuck_cnt != S_MAX) stuck_cnt <= stuck_cnt + 1'b1;
  end

  // Gated by clean so the flag drops in the same cycle the level falls.
  assign stuck = clean && (stuck_cnt == S_MAX);
`else
  assign stuck = 1'b0;
`endif
endmodule

module scp_signal_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 63
) (
  input  logic                      clock,
  input  logic                      reset,
  scp_signal_conditioner_if.slave   io
);
  localparam logic [1:0] ST_NONE   = 2'd0;
  localparam logic [1:0] ST_GREEN  = 2'd1;
  localparam logic [1:0] ST_YELLOW = 2'd2;
  localparam logic [1:0] ST_RED    = 2'd3;

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [2:0]    clean;
  logic [2:0]    stuck_ch;
  logic [2:0]    masked;
  logic [1:0]    state;
  logic [1:0]    req;
  logic [1:0]    nxt;
  logic [HW-1:0] hold_cnt;
  logic          hold_ok;

  // Bit order {red, yellow, green} throughout.
  scp_signal_conditioner_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_chan [2:0] (
    .clock (clock),
    .reset (reset),
    .raw   ({io.raw_red, io.raw_yellow, io.raw_green}),
    .clean (clean),
    .stuck (stuck_ch)
  );

  assign masked = clean & ~stuck_ch;

  // State encoding doubles as priority, so plain compares decide preemption.
  always_comb begin
    req = ST_NONE;
    if (masked[2])      req = ST_RED;
    else if (masked[1]) req = ST_YELLOW;
    else if (masked[0]) req = ST_GREEN;
    hold_ok = (hold_cnt >= HOLD_LAST);
    nxt = state;
    if ((req > state) || ((req < state) && hold_ok)) nxt = req;
  end

  // Outputs are registered from the next state so they land with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_NONE;
      hold_cnt   <= '0;
      io.green   <= 1'b0;
      io.yellow  <= 1'b0;
      io.red     <= 1'b0;
      io.changed <= 1'b0;
    end else begin
      state      <= nxt;
      io.changed <= (nxt != state);
      io.green   <= (nxt == ST_GREEN);
      io.yellow  <= (nxt == ST_YELLOW);
      io.red     <= (nxt == ST_RED);
      if (nxt != state) hold_cnt <= '0;
      else if (!hold_ok) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign io.level = state;
  assign io.stuck = stuck_ch;
endmodule

// File: tb/tb_scp_signal_conditioner.sv
// Scoreboard bench: stimulus queues expected level changes, monitor checks them.
module tb_scp_signal_conditioner;
  logic clock;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;

  typedef struct {
    logic [1:0] lvl;
    int         at;
  } exp_t;

  exp_t exp_q[$];

  scp_signal_conditioner_if bus();

  scp_signal_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8),
    .STUCK_CYCLES    (63)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_at(input logic [1:0] lvl, input int at);
    exp_t e;
    e.lvl = lvl;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d level changes still pending at cycle %0d", exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rgy"}, {bus.red, bus.yellow, bus.green}, 0);
    chk({name, "_level"}, bus.level, 0);
    chk({name, "_changed"}, bus.changed, 0);
    chk({name, "_stuck"}, bus.stuck, 0);
  endtask

  // Monitor: every changed pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && bus.changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_change_level", bus.level, -1);
      end else begin
        exp_t e;
        logic [2:0] onehot;
        e = exp_q.pop_front();
        chk("change_level", bus.level, e.lvl);
        chk("change_cycle", cyc, e.at);
        onehot = (e.lvl == 2'd1) ? 3'b001 : (e.lvl == 2'd2) ? 3'b010 :
                 (e.lvl == 2'd3) ? 3'b100 : 3'b000;
        chk("change_onehot", {bus.red, bus.yellow, bus.green}, onehot);
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.raw_green  = 1'b0;
    bus.raw_yellow = 1'b0;
    bus.raw_red    = 1'b1;

    // Reset held with raw_red asserted: everything stays low.
    repeat (4) @(negedge clock);
    chk_all_zero("in_reset");
    reset = 1'b0;
    expect_at(2'd3, cyc + 7);
    wait_drain(20);
    repeat (2) @(negedge clock);
    bus.raw_red = 1'b0;
    expect_at(2'd0, cyc + 7);
    wait_drain(20);

    // Three-cycle glitch must be swallowed by the debouncer.
    repeat (2) @(negedge clock);
    bus.raw_green = 1'b1;
    repeat (3) @(negedge clock);
    bus.raw_green = 1'b0;
    repeat (15) @(negedge clock);
    chk("glitch_level", bus.level, 0);

    // Red preempts green three cycles into green's hold.
    bus.raw_green = 1'b1;
    expect_at(2'd1, cyc + 7);
    repeat (3) @(negedge clock);
    bus.raw_red = 1'b1;
    expect_at(2'd3, cyc + 7);
    wait_drain(30);
    repeat (2) @(negedge clock);
    bus.raw_red   = 1'b0;
    bus.raw_green = 1'b0;
    expect_at(2'd0, cyc + 7);
    wait_drain(20);

    // Simultaneous red+yellow; red drops early, yellow waits for the 8-cycle hold.
    repeat (2) @(negedge clock);
    bus.raw_red    = 1'b1;
    bus.raw_yellow = 1'b1;
    expect_at(2'd3, cyc + 7);
    expect_at(2'd2, cyc + 15);
    repeat (5) @(negedge clock);
    bus.raw_red = 1'b0;
    wait_drain(30);

    // Reset in the middle of the yellow hold clears outputs at once.
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    repeat (3) @(negedge clock);
    chk("mid_reset_level_held", bus.level, 0);
    reset = 1'b0;
    expect_at(2'd2, cyc + 7);
    wait_drain(20);
    repeat (2) @(negedge clock);
    bus.raw_yellow = 1'b0;
    expect_at(2'd0, cyc + 7);
    wait_drain(20);

`ifdef SCP_SIGNAL_CONDITIONER_STUCK_DETECT_EN
    // Green held: after 63 clean-high cycles it is masked and falls to none.
    repeat (2) @(negedge clock);
    bus.raw_green = 1'b1;
    expect_at(2'd1, cyc + 7);
    expect_at(2'd0, cyc + 70);
    wait_drain(100);
    chk("stuck_set", bus.stuck, 3'b001);
    bus.raw_green = 1'b0;
    repeat (10) @(negedge clock);
    chk("stuck_clear", bus.stuck, 0);
`endif

    repeat (5) @(negedge clock);
    chk("final_level", bus.level, 0);
    chk("final_stuck", bus.stuck, 0);
    chk("final_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
